q_sys_timer_host_master: RTL and testbench

Avalon-MM initiator that drives the 16-bit register port of the system interval timer on behalf of fabric logic with no CPU. It accepts program, stop and snapshot commands, turns each into the timer's register write/read sequence, and services the timer `irq` by clearing status. It reports each timeout as a one-cycle `tick` pulse plus a running count. It sits between the TPU control logic and the timer slave inside `q_sys`.

---
 rtl/q_sys_timer_pkg.sv | 63 ++++++
 rtl/q_sys_timer_host_master.sv | 134 +++++++++++++
 tb/tb_q_sys_timer_host_master.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/q_sys_timer_pkg.sv
// Shared definitions for the system interval timer host: register map,
// control-word bit positions, host FSM states and bus-cycle helpers.
package q_sys_timer_pkg;

   localparam logic [2:0] ADDR_STATUS   = 3'd0;
   localparam logic [2:0] ADDR_CONTROL  = 3'd1;
   localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
   localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
   localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
   localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

   localparam int CTRL_ITO   = 0;
   localparam int CTRL_CONT  = 1;
   localparam int CTRL_START = 2;
   localparam int CTRL_STOP  = 3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_STOP,
      ST_WR_PL,
      ST_WR_PH,
      ST_START,
      ST_ARMED,
      ST_CLR,
      ST_HALT,
      ST_SNAP_WR,
      ST_RD_L,
      ST_WT_L,
      ST_RD_H,
      ST_WT_H
   } timer_host_state_t;

   typedef struct packed {
      logic        cs;
      logic        write_n;
      logic [2:0]  addr;
      logic [15:0] data;
   } bus_cmd_t;

   function automatic logic [15:0] ctrl_word(input logic stop, input logic start,
                                             input logic cont, input logic ito);
      logic [15:0] w;
      w             = '0;
      w[CTRL_STOP]  = stop;
      w[CTRL_START] = start;
      w[CTRL_CONT]  = cont;
      w[CTRL_ITO]   = ito;
      return w;
   endfunction

   function automatic bus_cmd_t bus_idle();
      return '{cs: 1'b0, write_n: 1'b1, addr: ADDR_STATUS, data: 16'h0000};
   endfunction

   function automatic bus_cmd_t bus_wr(input logic [2:0] a, input logic [15:0] d);
      return '{cs: 1'b1, write_n: 1'b0, addr: a, data: d};
   endfunction

   function automatic bus_cmd_t bus_rd(input logic [2:0] a);
      return '{cs: 1'b1, write_n: 1'b1, addr: a, data: 16'h0000};
   endfunction

endpackage

// File: rtl/q_sys_timer_host_master.sv
// Avalon-MM initiator that programs, stops and snapshots the interval timer
// and services its timeout interrupt, counting each serviced timeout.
//
// state    | meaning
// IDLE     | waiting for a command
// STOP     | force timer stop before reprogramming
// WR_PL/PH | write period low / high half
// START    | start timer with latched cont/ito
// ARMED    | timer running, watching irq / stop / snap
// CLR      | clear timeout status, count the tick
// HALT     | stop timer, return to IDLE
// SNAP_WR  | latch counter into snap registers
// RD_L/H   | read snap low / high
// WT_L/H   | capture returned read data
module q_sys_timer_host_master
   import q_sys_timer_pkg::*;
#(
   parameter int TICK_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [31:0]       cmd_period,
   input  logic              cmd_continuous,
   input  logic              cmd_irq_en,
   input  logic              stop_req,
   input  logic              snap_req,
   output logic              busy,
   output logic              tick,
   output logic [TICK_W-1:0] tick_count,
   output logic              snap_valid,
   output logic [31:0]       snap_value,
   output logic [2:0]        av_address,
   output logic              av_chipselect,
   output logic              av_write_n,
   output logic [15:0]       av_writedata,
   input  logic [15:0]       av_readdata,
   input  logic              irq
);

   timer_host_state_t state, state_next;
   bus_cmd_t          bus_next;

   logic [31:0] period_q;
   logic        cont_q;
   logic        ie_q;
   logic [15:0] snap_lo;

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      bus_next   = bus_idle();

      case (state)
         ST_IDLE:    if (cmd_valid) state_next = ST_STOP;
         ST_STOP:    state_next = ST_WR_PL;
         ST_WR_PL:   state_next = ST_WR_PH;
         ST_WR_PH:   state_next = ST_START;
         ST_START:   state_next = ST_ARMED;
         ST_ARMED: begin
            if (irq)           state_next = ST_CLR;
            else if (stop_req) state_next = ST_HALT;
            else if (snap_req) state_next = ST_SNAP_WR;
         end
         ST_CLR:     state_next = cont_q ? ST_ARMED : ST_IDLE;
         ST_HALT:    state_next = ST_IDLE;
         ST_SNAP_WR: state_next = ST_RD_L;
         ST_RD_L:    state_next = ST_WT_L;
         ST_WT_L:    state_next = ST_RD_H;
         ST_RD_H:    state_next = ST_WT_H;
         ST_WT_H:    state_next = ST_ARMED;
         default:    state_next = ST_IDLE;
      endcase

      // Bus outputs are registered from the next state so each access lines up with its state.
      case (state_next)
         ST_STOP,
         ST_HALT:    bus_next = bus_wr(ADDR_CONTROL, ctrl_word(1'b1, 1'b0, 1'b0, 1'b0));
         ST_WR_PL:   bus_next = bus_wr(ADDR_PERIOD_L, period_q[15:0]);
         ST_WR_PH:   bus_next = bus_wr(ADDR_PERIOD_H, period_q[31:16]);
         ST_START:   bus_next = bus_wr(ADDR_CONTROL, ctrl_word(1'b0, 1'b1, cont_q, ie_q));
         ST_CLR:     bus_next = bus_wr(ADDR_STATUS, 16'h0000);
         ST_SNAP_WR: bus_next = bus_wr(ADDR_SNAP_L, 16'h0000);
         ST_RD_L:    bus_next = bus_rd(ADDR_SNAP_L);
         ST_RD_H:    bus_next = bus_rd(ADDR_SNAP_H);
         default:    bus_next = bus_idle();
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         av_chipselect <= 1'b0;
         av_write_n    <= 1'b1;
         av_address    <= ADDR_STATUS;
         av_writedata  <= 16'h0000;
         tick          <= 1'b0;
         tick_count    <= '0;
         snap_valid    <= 1'b0;
         snap_value    <= 32'h0000_0000;
         snap_lo       <= 16'h0000;
         period_q      <= 32'h0000_0000;
         cont_q        <= 1'b0;
         ie_q          <= 1'b0;
      end else begin
         av_chipselect <= bus_next.cs;
         av_write_n    <= bus_next.write_n;
         av_address    <= bus_next.addr;
         av_writedata  <= bus_next.data;
         tick          <= (state == ST_CLR);
         snap_valid    <= (state == ST_WT_H);

         if (state == ST_IDLE && cmd_valid) begin
            period_q   <= cmd_period;
            cont_q     <= cmd_continuous;
            ie_q       <= cmd_irq_en;
            tick_count <= '0;
         end else if (state == ST_CLR) begin
            tick_count <= tick_count + TICK_W'(1);
         end

         if (state == ST_WT_L) snap_lo    <= av_readdata;
         if (state == ST_WT_H) snap_value <= {av_readdata, snap_lo};
      end
   end

   assign cmd_ready = (state == ST_IDLE);
   assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_q_sys_timer_host_master.sv
// Bench for q_sys_timer_host_master: behavioural interval-timer slave plus a
// scoreboard of expected bus cycles, ticks and snapshots.
module tb_q_sys_timer_host_master;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [31:0] cmd_period = '0;
   logic        cmd_continuous = 1'b0;
   logic        cmd_irq_en = 1'b0;
   logic        stop_req = 1'b0;
   logic        snap_req = 1'b0;
   logic        busy;
   logic        tick;
   logic [15:0] tick_count;
   logic        snap_valid;
   logic [31:0] snap_value;
   logic [2:0]  av_address;
   logic        av_chipselect;
   logic        av_write_n;
   logic [15:0] av_writedata;
   logic [15:0] av_readdata;
   logic        irq;

   q_sys_timer_host_master #(.TICK_W(16)) dut (
      .clk(clk), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_period(cmd_period),
      .cmd_continuous(cmd_continuous), .cmd_irq_en(cmd_irq_en),
      .stop_req(stop_req), .snap_req(snap_req), .busy(busy),
      .tick(tick), .tick_count(tick_count), .snap_valid(snap_valid), .snap_value(snap_value),
      .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
      .av_writedata(av_writedata), .av_readdata(av_readdata), .irq(irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Timer slave model: freeze holds the counter, force_to injects a timeout.
   logic        freeze = 1'b0;
   logic        force_to = 1'b0;
   logic        to_flag = 1'b0;
   logic        m_run = 1'b0;
   logic        m_cont = 1'b0;
   logic        m_ito = 1'b0;
   logic [31:0] m_per = '0;
   logic [31:0] m_cnt = '0;
   logic [31:0] m_snap = '0;
   logic [15:0] m_rd = '0;

   always @(posedge clk) begin
      if (m_run && !freeze) begin
         if (m_cnt == 32'd0) begin
            to_flag <= 1'b1;
            m_cnt   <= m_per;
            if (!m_cont) m_run <= 1'b0;
         end else begin
            m_cnt <= m_cnt - 32'd1;
         end
      end
      if (force_to) to_flag <= 1'b1;
      if (av_chipselect && !av_write_n) begin
         case (av_address)
            3'd0: to_flag <= 1'b0;
            3'd1: begin
               m_cont <= av_writedata[1];
               m_ito  <= av_writedata[0];
               if (av_writedata[2]) begin
                  m_run <= 1'b1;
                  m_cnt <= m_per;
               end else if (av_writedata[3]) begin
                  m_run <= 1'b0;
               end
            end
            3'd2: m_per[15:0]  <= av_writedata;
            3'd3: m_per[31:16] <= av_writedata;
            3'd4: m_snap       <= m_cnt;
            default: ;
         endcase
      end
      if (av_chipselect && av_write_n)
         m_rd <= (av_address == 3'd4) ? m_snap[15:0] :
                 (av_address == 3'd5) ? m_snap[31:16] : 16'h0000;
   end

   assign irq         = to_flag & m_ito;
   assign av_readdata = m_rd;

   // Scoreboard
   typedef struct {
      logic [2:0]  addr;
      logic        write_n;
      logic [15:0] data;
      logic        chk_data;
      int          gap;
   } bus_exp_t;

   typedef struct {
      logic [15:0] cnt;
      int          tgap;
      int          sgap;
   } tick_exp_t;

   bus_exp_t    exp_bus[$];
   tick_exp_t   exp_tick[$];
   logic [31:0] exp_snap[$];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic fail_event(input string name);
      checks++;
      errors++;
      $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc);
   endtask

   bus_exp_t    mb;
   tick_exp_t   mt;
   logic [31:0] ms;
   int last_bus  = -1000;
   int last_tick = -1000;
   int last_snap = -1000;

   always @(negedge clk) begin
      if (av_chipselect === 1'b1) begin
         if (exp_bus.size() == 0) fail_event("bus_unexpected");
         else begin
            mb = exp_bus.pop_front();
            chk("bus_addr", 32'(av_address), 32'(mb.addr));
            chk("bus_write_n", 32'(av_write_n), 32'(mb.write_n));
            if (mb.chk_data) chk("bus_data", 32'(av_writedata), 32'(mb.data));
            if (mb.gap != 0) chk("bus_gap", 32'(cyc - last_bus), 32'(mb.gap));
         end
         last_bus = cyc;
      end
      if (snap_valid === 1'b1) begin
         if (exp_snap.size() == 0) fail_event("snap_unexpected");
         else begin
            ms = exp_snap.pop_front();
            chk("snap_value", snap_value, ms);
         end
         last_snap = cyc;
      end
      if (tick === 1'b1) begin
         if (exp_tick.size() == 0) fail_event("tick_unexpected");
         else begin
            mt = exp_tick.pop_front();
            chk("tick_count", 32'(tick_count), 32'(mt.cnt));
            if (mt.tgap != 0) chk("tick_gap", 32'(cyc - last_tick), 32'(mt.tgap));
            if (mt.sgap != 0) chk("tick_after_snap", 32'(cyc - last_snap), 32'(mt.sgap));
         end
         last_tick = cyc;
      end
   end

   task automatic push_bus(input logic [2:0] a, input logic wn, input logic [15:0] d,
                           input logic cd, input int gap);
      bus_exp_t e;
      e.addr = a; e.write_n = wn; e.data = d; e.chk_data = cd; e.gap = gap;
      exp_bus.push_back(e);
   endtask

   task automatic push_tick(input logic [15:0] cnt, input int tgap, input int sgap);
      tick_exp_t e;
      e.cnt = cnt; e.tgap = tgap; e.sgap = sgap;
      exp_tick.push_back(e);
   endtask

   task automatic push_prog(input logic [31:0] p, input logic c, input logic ie);
      push_bus(3'd1, 1'b0, 16'h0008, 1'b1, 0);
      push_bus(3'd2, 1'b0, p[15:0], 1'b1, 1);
      push_bus(3'd3, 1'b0, p[31:16], 1'b1, 1);
      push_bus(3'd1, 1'b0, {12'h000, 1'b0, 1'b1, c, ie}, 1'b1, 1);
   endtask

   task automatic push_snap_seq();
      push_bus(3'd4, 1'b0, 16'h0000, 1'b0, 0);
      push_bus(3'd4, 1'b1, 16'h0000, 1'b0, 1);
      push_bus(3'd5, 1'b1, 16'h0000, 1'b0, 2);
   endtask

   task automatic issue_cmd(input logic [31:0] p, input logic c, input logic ie);
      int n;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
      cmd_period = p; cmd_continuous = c; cmd_irq_en = ie; cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < budget) begin @(negedge clk); n++; end
      chk(name, 32'(busy), 32'd0);
   endtask

   task automatic wait_ticks_done(input string name, input int budget);
      int n;
      n = 0;
      while (exp_tick.size() != 0 && n < budget) begin @(negedge clk); n++; end
      chk(name, 32'(exp_tick.size()), 32'd0);
   endtask

   task automatic pulse_stop();
      stop_req = 1'b1;
      @(negedge clk);
      stop_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      chk("rst_cs", 32'(av_chipselect), 32'd0);
      chk("rst_write_n", 32'(av_write_n), 32'd1);
      chk("rst_addr", 32'(av_address), 32'd0);
      chk("rst_wdata", 32'(av_writedata), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_tick_count", 32'(tick_count), 32'd0);
      chk("rst_snap_value", snap_value, 32'd0);
      reset = 1'b0;
      @(negedge clk);

      // Program sequence on a frozen timer, then halt
      freeze = 1'b1;
      push_prog(32'h0001_86A0, 1'b1, 1'b1);
      issue_cmd(32'h0001_86A0, 1'b1, 1'b1);
      chk("prog_busy", 32'(busy), 32'd1);
      chk("prog_cmd_ready", 32'(cmd_ready), 32'd0);
      repeat (3) @(negedge clk);
      chk("prog_busy_start", 32'(busy), 32'd1);
      repeat (3) @(negedge clk);
      push_bus(3'd1, 1'b0, 16'h0008, 1'b1, 0);
      pulse_stop();
      wait_idle("prog_halt_idle", 20);

      // Continuous ticks, period 9
      freeze = 1'b0;
      push_prog(32'd9, 1'b1, 1'b1);
      for (int i = 1; i <= 5; i++) begin
         push_bus(3'd0, 1'b0, 16'h0000, 1'b1, (i == 1) ? 0 : 10);
         push_tick(16'(i), (i == 1) ? 0 : 10, 0);
      end
      issue_cmd(32'd9, 1'b1, 1'b1);
      wait_ticks_done("cont_ticks_done", 300);
      chk("cont_tick_count", 32'(tick_count), 32'd5);
      push_bus(3'd1, 1'b0, 16'h0008, 1'b1, 0);
      pulse_stop();
      wait_idle("cont_halt_idle", 20);

      // One-shot, period 4
      push_prog(32'd4, 1'b0, 1'b1);
      push_bus(3'd0, 1'b0, 16'h0000, 1'b1, 0);
      push_tick(16'd1, 0, 0);
      issue_cmd(32'd4, 1'b0, 1'b1);
      wait_idle("oneshot_idle", 100);
      chk("oneshot_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("oneshot_tick_count", 32'(tick_count), 32'd1);

      // Snapshot of a frozen counter at 0x0001_2345
      freeze = 1'b1;
      push_prog(32'h0001_2345, 1'b1, 1'b1);
      issue_cmd(32'h0001_2345, 1'b1, 1'b1);
      repeat (6) @(negedge clk);
      push_snap_seq();
      exp_snap.push_back(32'h0001_2345);
      snap_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0;
      n = 0;
      while (exp_snap.size() != 0 && n < 50) begin @(negedge clk); n++; end
      chk("snap_done", 32'(exp_snap.size()), 32'd0);

      // irq raised while the snapshot is in flight
      push_snap_seq();
      push_bus(3'd0, 1'b0, 16'h0000, 1'b1, 0);
      exp_snap.push_back(32'h0001_2345);
      push_tick(16'd1, 0, 2);
      snap_req = 1'b1; force_to = 1'b1;
      @(negedge clk);
      snap_req = 1'b0; force_to = 1'b0;
      wait_ticks_done("snap_irq_tick", 50);

      // irq and stop_req together: clear wins, stop is dropped
      push_bus(3'd0, 1'b0, 16'h0000, 1'b1, 0);
      push_tick(16'd2, 0, 0);
      force_to = 1'b1;
      @(negedge clk);
      force_to = 1'b0; stop_req = 1'b1;
      @(negedge clk);
      stop_req = 1'b0;
      wait_ticks_done("collide_tick", 20);
      repeat (5) @(negedge clk);
      chk("collide_stop_dropped", 32'(busy), 32'd1);
      push_bus(3'd1, 1'b0, 16'h0008, 1'b1, 0);
      pulse_stop();
      wait_idle("collide_halt_idle", 20);

      // Requests in IDLE are ignored
      snap_req = 1'b1; stop_req = 1'b1;
      @(negedge clk);
      snap_req = 1'b0; stop_req = 1'b0;
      repeat (4) @(negedge clk);
      chk("idle_req_dropped", 32'(busy), 32'd0);

      // Reset during WR_PH, period 0 passed through
      push_bus(3'd1, 1'b0, 16'h0008, 1'b1, 0);
      push_bus(3'd2, 1'b0, 16'h0000, 1'b1, 1);
      push_bus(3'd3, 1'b0, 16'h0000, 1'b1, 1);
      issue_cmd(32'h0000_0000, 1'b1, 1'b1);
      n = 0;
      while (!(av_chipselect === 1'b1 && av_address == 3'd3) && n < 20) begin
         @(negedge clk); n++;
      end
      chk("rst_mid_reach_wr_ph", 32'(av_address), 32'd3);
      reset = 1'b1;
      @(negedge clk);
      chk("rst_mid_cs", 32'(av_chipselect), 32'd0);
      chk("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_tick_count", 32'(tick_count), 32'd0);
      chk("rst_mid_write_n", 32'(av_write_n), 32'd1);
      reset = 1'b0;
      repeat (4) @(negedge clk);

      chk("end_bus_queue", 32'(exp_bus.size()), 32'd0);
      chk("end_tick_queue", 32'(exp_tick.size()), 32'd0);
      chk("end_snap_queue", 32'(exp_snap.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
